pwm_timebase_multi: RTL
=======================

# pwm_timebase_multi

Parametrised PWM timebase with N compare channels, shadow-loaded period/compare registers, selectable count mode, phase synchronisation and per-channel complementary deadband outputs. It is the next-generation PWM core: one instance replaces a counter, its comparators and its deadband units, and instances chain via `o_sync`/`i_sync_in` for phase-shifted multi-phase generation. It is driven from the register file, with outputs going to the pads.

## Interface
- `CNT_W`, default 16: counter, period, compare and phase width.
- `NUM_CH`, default 2: number of compare channels.
- `DB_W`, default 4: deadband delay width.

Ports:
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_en`, in, 1: timebase enable.
- `i_mode`, in, 2: count mode. 00 = up, 01 = down, 10 = up-down, 11 = freeze.
- `i_load_mode`, in, 1: 0 = active regs follow inputs every cycle; 1 = shadow load at zero.
- `i_period`, in, CNT_W: period P.
- `i_compare`, in, NUM_CH*CNT_W: compare values; channel k is at bits [k*CNT_W +: CNT_W].
- `i_sync_en`, in, 1: accept `i_sync_in`.
- `i_sync_in`, in, 1: phase-load strobe.
- `i_phase`, in, CNT_W: value loaded on sync.
- `i_red`, in, NUM_CH*DB_W: rising-edge delay per channel.
- `i_fed`, in, NUM_CH*DB_W: falling-edge delay per channel.
- `o_counter`, out, CNT_W: current count.
- `o_sync`, out, 1: high for one cycle when the counter equals 0.
- `o_pwm`, out, NUM_CH: deadbanded PWM.
- `o_pwm_n`, out, NUM_CH: deadbanded complement.

## Operation
**Reset**
- All outputs are 0.
- The counter is 0 and the direction is up.
- Active period/compare registers are 0.
- Deadband counters are 0.

**Disable**
- While `i_en` = 0, the counter is forced to 0 with direction up.
- `o_pwm` and `o_pwm_n` are 0.
- Deadband counters are cleared.
- `o_sync` is 0.

**Count modes**
- Up: 0, 1, …, P, 0. Cycle length is P+1.
- Down: P, P-1, …, 0, P. Cycle length is P+1.
- Up-down: 0 up to P, then down to 0, then up again.
  - Direction flips at P and at 0.
  - Cycle length is 2P.
- Freeze: the counter holds its value. Comparators and deadband keep running.
- P = 0: the counter stays at 0 and `o_sync` is high every enabled cycle.
- Mode change mid-period takes effect from the current count.
  - A count above P is treated as wrap: up mode goes to 0, down mode goes to P.

**Shadow load**
- When `i_load_mode` = 1, the active P and compare values copy from the inputs on the cycle the counter transitions to 0.
- When `i_load_mode` = 0, they copy every cycle.
- Counting and comparison always use the active values.

**Sync**
- If `i_sync_en` && `i_sync_in`, the counter loads min(`i_phase`, P) on the next edge and the direction becomes up.
- Sync has priority over normal counting.
- Sync is ignored while `i_en` = 0 or in freeze mode.

**Compare**
- raw_k is registered as (counter < cmp_k).
- cmp_k = 0 gives a permanently low output.
- cmp_k > P gives a permanently high output.

**Deadband, per channel**
- A rising edge of raw_k starts a red_k countdown. `o_pwm` rises when it expires, with `o_pwm_n` already low.
- A falling edge starts a fed_k countdown. `o_pwm_n` rises when it expires, with `o_pwm` dropping immediately.
- Delay 0 means no delay.
- A raw pulse shorter than its delay is swallowed: the opposite edge restarts the other countdown and both outputs stay low until it expires.
- `o_pwm` && `o_pwm_n` is never 1.

## Timing
- `o_counter` is registered. It shows the next value one cycle after the decision that produced it.
- `o_sync` is registered and coincident with `o_counter` = 0.
- raw_k updates one cycle after `o_counter`. `o_pwm` updates one cycle after raw_k plus red/fed cycles. With zero deadband, `o_pwm` lags `o_counter` by 2 cycles.
- Sync asserted at edge n gives `o_counter` = phase after edge n+1.
- A shadow load at the zero point is visible to the compare on that same zero count.
- Asynchronous reset mid-operation clears everything immediately. The first count after release is 0 in up and up-down modes, and P in down mode on the first enabled cycle.

## Test plan
- Up mode, P=4, cmp0=2, no deadband -> `o_counter` runs 0,1,2,3,4,0. `o_pwm[0]` is high 2 of every 5 cycles. `o_sync` pulses every 5 cycles.
- Up-down mode, P=4, cmp0=2 -> counter runs 0,1,2,3,4,3,2,1 with period 8. `o_pwm[0]` is high 3 of every 8 cycles. `o_sync` fires once per 8 cycles.
- Deadband red=2, fed=3, raw high for 10 cycles -> `o_pwm` is high for 8 cycles, starting 2 cycles late. `o_pwm_n` rises 3 cycles after raw falls. Both outputs are never high together, including when raw is high for only 1 cycle (swallowed).
- Shadow load: `i_load_mode`=1, P=9, cmp 3→7 written at count 5 -> duty stays 3/10 for the remainder of the period and becomes 7/10 from the next zero.
- Chained sync: instance A `o_sync` drives instance B with `i_phase`=3 and P=9 -> B's counter equals 3 one cycle after every A zero. B with `i_phase`=20 loads 9.
- Asynchronous reset asserted at count 6 -> all outputs are 0 immediately. After release, counting restarts from 0 and cmp=0 keeps `o_pwm` low.

Source files
------------

// File: rtl/pwm_timebase_multi.sv
// Multi-channel PWM timebase: shadowed period/compare, up/down/up-down/freeze counting,
// phase sync for chaining, and per-channel complementary deadband outputs.
module pwm_timebase_multi #(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 2,
    parameter int DB_W   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic [1:0]              i_mode,
    input  logic                    i_load_mode,
    input  logic [CNT_W-1:0]        i_period,
    input  logic [NUM_CH*CNT_W-1:0] i_compare,
    input  logic                    i_sync_en,
    input  logic                    i_sync_in,
    input  logic [CNT_W-1:0]        i_phase,
    input  logic [NUM_CH*DB_W-1:0]  i_red,
    input  logic [NUM_CH*DB_W-1:0]  i_fed,
    output logic [CNT_W-1:0]        o_counter,
    output logic                    o_sync,
    output logic [NUM_CH-1:0]       o_pwm,
    output logic [NUM_CH-1:0]       o_pwm_n
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_UPDN   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_t;

    mode_t            mode;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] phase_clamped;
    logic             dir_down_reg, dir_down_next;
    logic             sync_reg;
    logic             sync_take;
    logic             shadow_load;

    assign mode = mode_t'(i_mode);

    always_comb begin
        cnt_next      = cnt_reg;
        dir_down_next = dir_down_reg;
        phase_clamped = (i_phase > period_reg) ? period_reg : i_phase;
        sync_take     = i_sync_en && i_sync_in && (mode != MODE_FREEZE);
        if (!i_en) begin
            cnt_next      = '0;
            dir_down_next = 1'b0;
        end else if (sync_take) begin
            cnt_next      = phase_clamped;
            dir_down_next = 1'b0;
        end else begin
            case (mode)
                MODE_UP: begin
                    dir_down_next = 1'b0;
                    cnt_next      = (cnt_reg >= period_reg) ? '0 : cnt_reg + 1'b1;
                end
                MODE_DOWN: begin
                    dir_down_next = 1'b1;
                    cnt_next      = (cnt_reg == '0 || cnt_reg > period_reg) ? period_reg
                                                                            : cnt_reg - 1'b1;
                end
                MODE_UPDN: begin
                    // Turn around at P going up and at 0 going down; P = 0 parks at zero.
                    if (period_reg == '0) begin
                        cnt_next      = '0;
                        dir_down_next = 1'b0;
                    end else if (!dir_down_reg) begin
                        if (cnt_reg >= period_reg) begin
                            cnt_next      = period_reg - 1'b1;
                            dir_down_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end else if (cnt_reg == '0) begin
                        cnt_next      = CNT_W'(1);
                        dir_down_next = 1'b0;
                    end else if (cnt_reg > period_reg) begin
                        cnt_next = period_reg;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: cnt_next = cnt_reg;
            endcase
        end
        shadow_load = !i_load_mode || (cnt_next == '0);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_reg      <= '0;
            dir_down_reg <= 1'b0;
            sync_reg     <= 1'b0;
            period_reg   <= '0;
        end else begin
            cnt_reg      <= cnt_next;
            dir_down_reg <= dir_down_next;
            sync_reg     <= i_en && (cnt_next == '0);
            if (shadow_load) begin
                period_reg <= i_period;
            end
        end
    end

    assign o_counter = cnt_reg;
    assign o_sync    = sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cmp_reg;
            logic             raw_reg, raw_d_reg;
            logic             pwm_reg, pwm_n_reg;
            logic [DB_W-1:0]  db_cnt_reg;
            logic [DB_W-1:0]  edge_delay;

            assign edge_delay = raw_reg ? i_red[gi*DB_W +: DB_W] : i_fed[gi*DB_W +: DB_W];

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    cmp_reg    <= '0;
                    raw_reg    <= 1'b0;
                    raw_d_reg  <= 1'b0;
                    pwm_reg    <= 1'b0;
                    pwm_n_reg  <= 1'b0;
                    db_cnt_reg <= '0;
                end else begin
                    if (shadow_load) begin
                        cmp_reg <= i_compare[gi*CNT_W +: CNT_W];
                    end
                    if (!i_en) begin
                        raw_reg    <= 1'b0;
                        raw_d_reg  <= 1'b0;
                        pwm_reg    <= 1'b0;
                        pwm_n_reg  <= 1'b0;
                        db_cnt_reg <= '0;
                    end else begin
                        raw_reg   <= (cnt_reg < cmp_reg);
                        raw_d_reg <= raw_reg;
                        // Any raw edge drops both outputs and (re)starts the countdown,
                        // which is what swallows pulses shorter than the delay.
                        if (raw_reg != raw_d_reg) begin
                            if (edge_delay == '0) begin
                                pwm_reg    <= raw_reg;
                                pwm_n_reg  <= !raw_reg;
                                db_cnt_reg <= '0;
                            end else begin
                                pwm_reg    <= 1'b0;
                                pwm_n_reg  <= 1'b0;
                                db_cnt_reg <= edge_delay;
                            end
                        end else if (db_cnt_reg > DB_W'(1)) begin
                            db_cnt_reg <= db_cnt_reg - 1'b1;
                        end else begin
                            db_cnt_reg <= '0;
                            pwm_reg    <= raw_reg;
                            pwm_n_reg  <= !raw_reg;
                        end
                    end
                end
            end

            assign o_pwm[gi]   = pwm_reg;
            assign o_pwm_n[gi] = pwm_n_reg;
        end
    endgenerate

endmodule
